// File: rtl/gouram_trace_drain.sv
// gouram_trace_drain
//   Consumer end of the Gouram trace output. Buffers RECORD_WIDTH-bit trace
//   records in a FIFO and serialises each one, least significant word first,
//   onto a WORD_WIDTH-bit valid/ready stream. The trace unit cannot be
//   stalled, so records that arrive while the FIFO is full are dropped and
//   counted.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   trace_data_i      record from the trace unit
//   trace_valid_i     record valid this cycle
//   clear_i           synchronous clear of counters and overflow flag
//   word_o            current output beat
//   word_valid_o      beat valid
//   word_ready_i      sink accepts beat
//   word_last_o       final beat of a record
//   fifo_level_o      occupied FIFO entries (excludes the record being sent)
//   record_count_o    records accepted (wraps)
//   drop_count_o      records dropped (saturates)
//   overflow_o        sticky: at least one drop since reset/clear
//
// FSM
//   IDLE | shift register empty, waiting for a buffered record
//   SEND | presenting beat beat_q of the record held in shift_q
module gouram_trace_drain #(
  parameter int FIFO_DEPTH   = 8,
  parameter int RECORD_WIDTH = 160,
  parameter int WORD_WIDTH   = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [RECORD_WIDTH-1:0]       trace_data_i,
  input  logic                          trace_valid_i,
  input  logic                          clear_i,
  output logic [WORD_WIDTH-1:0]         word_o,
  output logic                          word_valid_o,
  input  logic                          word_ready_i,
  output logic                          word_last_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic [31:0]                   record_count_o,
  output logic [15:0]                   drop_count_o,
  output logic                          overflow_o
);

  localparam int BEATS = RECORD_WIDTH / WORD_WIDTH;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int LW    = PW + 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [RECORD_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]           level_q, level_d;
  logic [RECORD_WIDTH-1:0] shift_q;
  logic [BW-1:0]           beat_q;
  logic [31:0]             record_count_q;
  logic [15:0]             drop_count_q;
  logic                    overflow_q;

  logic non_empty, full, last_beat, hs, pop, push, drop;

  assign non_empty = (level_q != '0);
  assign full      = (level_q == LW'(FIFO_DEPTH));
  assign last_beat = (beat_q == BW'(BEATS - 1));

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (non_empty) state_d = SEND;
      SEND: if (hs && last_beat && !non_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. The head is popped either from IDLE or on the final
  // handshake of a record, which gives back-to-back records with no bubble.
  always_comb begin
    word_valid_o = (state_q == SEND);
    word_last_o  = (state_q == SEND) && last_beat;
    word_o       = shift_q[WORD_WIDTH-1:0];
    hs           = (state_q == SEND) && word_ready_i;
    pop          = ((state_q == IDLE) && non_empty) ||
                   (hs && last_beat && non_empty);
  end

  // A full FIFO still accepts a record when the same edge pops the head.
  always_comb begin
    push    = trace_valid_i && (!full || pop);
    drop    = trace_valid_i && full && !pop;
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage is not reset; only entries below the level are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= trace_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      shift_q  <= '0;
      beat_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_d;
      if (pop) begin
        shift_q <= mem_q[rd_ptr_q];
        beat_q  <= '0;
      end else if (hs && !last_beat) begin
        shift_q <= shift_q >> WORD_WIDTH;
        beat_q  <= beat_q + BW'(1);
      end
    end
  end

  // Counters; clear takes priority over a same-cycle push or drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      record_count_q <= '0;
      drop_count_q   <= '0;
      overflow_q     <= 1'b0;
    end else if (clear_i) begin
      record_count_q <= '0;
      drop_count_q   <= '0;
      overflow_q     <= 1'b0;
    end else begin
      if (push) record_count_q <= record_count_q + 32'd1;
      if (drop) begin
        if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
        overflow_q <= 1'b1;
      end
    end
  end

  assign fifo_level_o   = level_q;
  assign record_count_o = record_count_q;
  assign drop_count_o   = drop_count_q;
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_gouram_trace_drain.sv
module tb_gouram_trace_drain;

  localparam int FD    = 8;
  localparam int RW    = 160;
  localparam int WW    = 32;
  localparam int BEATS = RW / WW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] trace_data_i;
  logic          trace_valid_i;
  logic          clear_i;
  logic [WW-1:0] word_o;
  logic          word_valid_o;
  logic          word_ready_i;
  logic          word_last_o;
  logic [3:0]    fifo_level_o;
  logic [31:0]   record_count_o;
  logic [15:0]   drop_count_o;
  logic          overflow_o;

  always #5 clk = ~clk;

  gouram_trace_drain #(.FIFO_DEPTH(FD), .RECORD_WIDTH(RW), .WORD_WIDTH(WW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .trace_data_i   (trace_data_i),
    .trace_valid_i  (trace_valid_i),
    .clear_i        (clear_i),
    .word_o         (word_o),
    .word_valid_o   (word_valid_o),
    .word_ready_i   (word_ready_i),
    .word_last_o    (word_last_o),
    .fifo_level_o   (fifo_level_o),
    .record_count_o (record_count_o),
    .drop_count_o   (drop_count_o),
    .overflow_o     (overflow_o)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          beats_seen = 0;
  int          b0;
  logic [32:0] exp_q[$];
  logic [32:0] e;
  logic        held_v = 1'b0;
  logic [31:0] held_w;
  logic        held_l;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [RW-1:0] mkrec(input int base);
    logic [RW-1:0] r;
    r = '0;
    for (int k = 0; k < BEATS; k++) r[k*WW +: WW] = WW'(base + k + 1);
    return r;
  endfunction

  task automatic push_set(input int base, input bit acc);
    trace_data_i  = mkrec(base);
    trace_valid_i = 1'b1;
    if (acc)
      for (int k = 0; k < BEATS; k++) exp_q.push_back({(k == BEATS - 1), 32'(base + k + 1)});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    word_ready_i = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !word_valid_o) break;
      cyc();
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_valid_low", word_valid_o, 0);
    chk("drain_level", fifo_level_o, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_word"},  word_o, 0);
    chk({tag, "_valid"}, word_valid_o, 0);
    chk({tag, "_last"},  word_last_o, 0);
    chk({tag, "_level"}, fifo_level_o, 0);
    chk({tag, "_rc"},    record_count_o, 0);
    chk({tag, "_dc"},    drop_count_o, 0);
    chk({tag, "_ovf"},   overflow_o, 0);
  endtask

  // Stream monitor: every handshake must match the next expected beat, and a
  // stalled beat must hold word/last stable until accepted.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("hold_valid", word_valid_o, 1);
        chk("hold_word", word_o, held_w);
        chk("hold_last", word_last_o, held_l);
      end
      if (word_valid_o && word_ready_i) begin
        beats_seen++;
        n_cmp++;
        assert (exp_q.size() != 0)
        else begin
          n_err++;
          $error("FAIL unexpected_beat: observed word 0x%0h expected none", word_o);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat_word", word_o, e[31:0]);
          chk("beat_last", word_last_o, e[32]);
        end
        held_v = 1'b0;
      end else if (word_valid_o) begin
        held_v = 1'b1;
        held_w = word_o;
        held_l = word_last_o;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; trace_data_i = '0; trace_valid_i = 1'b0;
    clear_i = 1'b0; word_ready_i = 1'b0;
    cyc(); cyc();
    chk_all_zero("reset");
    rst_n = 1'b1;
    cyc();

    // single record, beat k = k+1
    word_ready_i = 1'b1;
    push_set(0, 1'b1);
    cyc();
    trace_valid_i = 1'b0;
    chk("t1_level_after_push", fifo_level_o, 1);
    chk("t1_valid_before_pop", word_valid_o, 0);
    chk("t1_rc", record_count_o, 1);
    cyc();
    chk("t1_valid_first", word_valid_o, 1);
    chk("t1_word_first", word_o, 1);
    chk("t1_last_first", word_last_o, 0);
    chk("t1_level_after_pop", fifo_level_o, 0);
    b0 = beats_seen;
    repeat (5) cyc();
    chk("t1_beats", beats_seen - b0, 5);
    chk("t1_valid_end", word_valid_o, 0);
    chk("t1_queue", exp_q.size(), 0);

    // three records back to back, no bubble
    b0 = beats_seen;
    for (int i = 0; i < 3; i++) begin
      push_set(256 * (i + 1), 1'b1);
      cyc();
    end
    trace_valid_i = 1'b0;
    repeat (14) cyc();
    chk("t2_beats", beats_seen - b0, 15);
    chk("t2_valid_end", word_valid_o, 0);
    chk("t2_level", fifo_level_o, 0);
    chk("t2_queue", exp_q.size(), 0);
    chk("t2_rc", record_count_o, 4);

    clear_i = 1'b1;
    cyc();
    clear_i = 1'b0;
    chk("clr_rc", record_count_o, 0);

    // ready low throughout, 12 pushes: 1 in shift reg, 8 buffered, 3 dropped
    word_ready_i = 1'b0;
    for (int k = 0; k < 12; k++) begin
      push_set(32'h1000 + 16 * k, k < 9);
      cyc();
    end
    trace_valid_i = 1'b0;
    chk("t3_level", fifo_level_o, 8);
    chk("t3_dc", drop_count_o, 3);
    chk("t3_ovf", overflow_o, 1);
    chk("t3_rc", record_count_o, 9);
    chk("t3_valid", word_valid_o, 1);
    chk("t3_word", word_o, 32'h1001);
    b0 = beats_seen;
    word_ready_i = 1'b1;
    repeat (45) cyc();
    chk("t3_beats", beats_seen - b0, 45);
    chk("t3_valid_end", word_valid_o, 0);
    chk("t3_level_end", fifo_level_o, 0);
    chk("t3_queue", exp_q.size(), 0);

    // ready toggling during one record
    word_ready_i = 1'b0;
    push_set(32'h2000, 1'b1);
    cyc();
    trace_valid_i = 1'b0;
    cyc();
    chk("t4_valid", word_valid_o, 1);
    b0 = beats_seen;
    for (int i = 0; i < 12; i++) begin
      word_ready_i = (i % 2 == 0);
      cyc();
    end
    word_ready_i = 1'b0;
    chk("t4_beats", beats_seen - b0, 5);
    chk("t4_valid_end", word_valid_o, 0);
    chk("t4_queue", exp_q.size(), 0);

    // full FIFO, push coincides with the last-beat handshake
    for (int k = 0; k < 9; k++) begin
      push_set(32'h3000 + 16 * k, 1'b1);
      cyc();
    end
    trace_valid_i = 1'b0;
    chk("t5_level_full", fifo_level_o, 8);
    word_ready_i = 1'b1;
    repeat (4) cyc();
    chk("t5_at_last", word_last_o, 1);
    push_set(32'h4000, 1'b1);
    cyc();
    trace_valid_i = 1'b0;
    chk("t5_level", fifo_level_o, 8);
    chk("t5_dc", drop_count_o, 3);
    chk("t5_rc", record_count_o, 20);
    drain(100);

    // reset mid-record with 4 records buffered
    word_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      push_set(32'h5000 + 16 * k, 1'b1);
      cyc();
    end
    trace_valid_i = 1'b0;
    chk("t6_level", fifo_level_o, 4);
    word_ready_i = 1'b1;
    cyc(); cyc();
    word_ready_i = 1'b0;
    chk("t6_word_beat3", word_o, 32'h5003);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    exp_q.delete();
    cyc(); cyc();
    rst_n = 1'b1;
    word_ready_i = 1'b1;
    b0 = beats_seen;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t6_quiet_valid", word_valid_o, 0);
    end
    chk("t6_quiet_beats", beats_seen - b0, 0);

    // drops, then clear together with a would-be drop
    word_ready_i = 1'b0;
    for (int k = 0; k < 11; k++) begin
      push_set(32'h6000 + 16 * k, k < 9);
      cyc();
    end
    trace_valid_i = 1'b0;
    chk("t7_dc", drop_count_o, 2);
    chk("t7_ovf", overflow_o, 1);
    chk("t7_rc", record_count_o, 9);
    chk("t7_level", fifo_level_o, 8);
    clear_i = 1'b1;
    push_set(32'h7000, 1'b0);
    cyc();
    clear_i = 1'b0;
    trace_valid_i = 1'b0;
    chk("t7_clr_dc", drop_count_o, 0);
    chk("t7_clr_ovf", overflow_o, 0);
    chk("t7_clr_rc", record_count_o, 0);
    chk("t7_clr_level", fifo_level_o, 8);
    drain(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
